// File: rtl/usb_data_buffer.sv
// Byte FIFO shared by the USB slave and RX/TX packet engines, with show-ahead head outputs.
// Define USB_BUFFER_ERR_FLAGS_EN to add the sticky buffer_error output.
module usb_data_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [7:0]        tx_data,
    input  logic              get_rx_data,
    output logic [7:0]        rx_data,
    input  logic              store_rx_packet_data,
    input  logic [7:0]        rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [7:0]        tx_packet_data,
`ifdef USB_BUFFER_ERR_FLAGS_EN
    output logic              buffer_error,
`endif
    output logic [ADDR_W:0]   buffer_occupancy
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic       push, pop_req, empty, full, do_push, do_pop;
    logic [7:0] push_byte, head;

    assign push      = store_tx_data | store_rx_packet_data;
    // Slave write wins a collision; the RX engine byte is dropped.
    assign push_byte = store_tx_data ? tx_data : rx_packet_data;
    assign pop_req   = get_rx_data | get_tx_packet_data;
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);

    // A push into a full buffer is only accepted when a pop frees the slot in the same cycle.
    assign do_push = push & ~clear & (~full | pop_req);
    assign do_pop  = pop_req & ~clear & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_byte;
    end

    assign head             = empty ? 8'h00 : mem[rptr_q];
    assign rx_data          = head;
    assign tx_packet_data   = head;
    assign buffer_occupancy = cnt_q;

`ifdef USB_BUFFER_ERR_FLAGS_EN
    logic err_q, err_d, err_set;

    assign err_set = (push & full & ~pop_req) | (pop_req & empty)
                   | (store_tx_data & store_rx_packet_data);

    always_comb begin
        err_d = err_q | err_set;
        if (clear) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign buffer_error = err_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer; a queue holds the bytes expected at the head.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_rx_data;
    logic [7:0] rx_data;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
`ifdef USB_BUFFER_ERR_FLAGS_EN
    logic       buffer_error;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    usb_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
`ifdef USB_BUFFER_ERR_FLAGS_EN
        .buffer_error         (buffer_error),
`endif
        .buffer_occupancy     (buffer_occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic idle_inputs();
        clear = 0; store_tx_data = 0; store_rx_packet_data = 0;
        get_rx_data = 0; get_tx_packet_data = 0; tx_data = 0; rx_packet_data = 0;
    endtask

    task automatic step(input logic s_tx, input logic [7:0] d_tx, input logic s_rx,
                        input logic [7:0] d_rx, input logic g_rx, input logic g_tx,
                        input logic clr);
        store_tx_data = s_tx; tx_data = d_tx;
        store_rx_packet_data = s_rx; rx_packet_data = d_rx;
        get_rx_data = g_rx; get_tx_packet_data = g_tx; clear = clr;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic pop_check(input string tag, input logic use_tx);
        e = exp_q.pop_front();
        chk(tag, use_tx ? tx_packet_data : rx_data, e);
        step(0, 8'h00, 0, 8'h00, !use_tx, use_tx, 0);
    endtask

    initial begin
        n_rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_occ", {1'b0, buffer_occupancy}, 8'd0);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_tx_pkt", tx_packet_data, 8'h00);
`ifdef USB_BUFFER_ERR_FLAGS_EN
        chk("reset_err", {7'b0, buffer_error}, 8'd0);
`endif
        n_rst = 1;
        @(negedge clk);

        // Single slave push, seen on both head outputs.
        exp_q.push_back(8'hA5);
        step(1, 8'hA5, 0, 8'h00, 0, 0, 0);
        chk("t1_occ", {1'b0, buffer_occupancy}, 8'd1);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_tx_pkt", tx_packet_data, 8'hA5);
        pop_check("t1_pop", 0);
        chk("t1_occ_empty", {1'b0, buffer_occupancy}, 8'd0);

        // Fill via RX engine, then overflow.
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(8'(i));
            step(0, 8'h00, 1, 8'(i), 0, 0, 0);
        end
        chk("t2_occ_full", {1'b0, buffer_occupancy}, 8'd64);
        step(0, 8'h00, 1, 8'hFF, 0, 0, 0);
        chk("t2_occ_overflow", {1'b0, buffer_occupancy}, 8'd64);
        chk("t2_head_after_ovf", rx_data, 8'h00);
`ifdef USB_BUFFER_ERR_FLAGS_EN
        chk("t2_err", {7'b0, buffer_error}, 8'd1);
`endif

        // Push and pop together while full.
        e = exp_q.pop_front();
        chk("t3_popped", tx_packet_data, e);
        exp_q.push_back(8'h77);
        step(0, 8'h00, 1, 8'h77, 0, 1, 0);
        chk("t3_occ", {1'b0, buffer_occupancy}, 8'd64);
        for (int i = 0; i < 64; i++) pop_check($sformatf("t3_drain%0d", i), i[0]);
        chk("t3_occ_empty", {1'b0, buffer_occupancy}, 8'd0);

        // Streaming push/pop across pointer wrap.
        exp_q.push_back(8'h80);
        step(1, 8'h80, 0, 8'h00, 0, 0, 0);
        exp_q.push_back(8'h81);
        step(1, 8'h81, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            e = exp_q.pop_front();
            chk($sformatf("t4_wrap%0d", i), rx_data, e);
            exp_q.push_back(8'(8'h82 + i));
            step(i[0], 8'(8'h82 + i), !i[0], 8'(8'h82 + i), 1, i[1], 0);
        end
        chk("t4_occ", {1'b0, buffer_occupancy}, 8'd2);
        pop_check("t4_last0", 0);
        pop_check("t4_last1", 1);

        // Collision: slave byte wins.
        exp_q.push_back(8'h3C);
        step(1, 8'h3C, 1, 8'hC3, 0, 0, 0);
        chk("col_occ", {1'b0, buffer_occupancy}, 8'd1);
        pop_check("col_head", 0);

        // Underflow, then clear with a concurrent push.
        step(0, 8'h00, 0, 8'h00, 1, 0, 0);
        chk("t5_occ", {1'b0, buffer_occupancy}, 8'd0);
        chk("t5_rx_data", rx_data, 8'h00);
`ifdef USB_BUFFER_ERR_FLAGS_EN
        chk("t5_err_set", {7'b0, buffer_error}, 8'd1);
`endif
        step(1, 8'h12, 0, 8'h00, 0, 0, 1);
        chk("t5_clear_occ", {1'b0, buffer_occupancy}, 8'd0);
        chk("t5_clear_head", rx_data, 8'h00);
`ifdef USB_BUFFER_ERR_FLAGS_EN
        chk("t5_err_clr", {7'b0, buffer_error}, 8'd0);
`endif

        // Asynchronous reset in the middle of a push.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 8'h00, 0, 0, 0);
        chk("t6_occ5", {1'b0, buffer_occupancy}, 8'd5);
        chk("t6_head", rx_data, 8'h50);
        store_tx_data = 1; tx_data = 8'h99;
        #2 n_rst = 0;
        #1;
        chk("t6_occ_rst", {1'b0, buffer_occupancy}, 8'd0);
        chk("t6_rx_rst", rx_data, 8'h00);
        chk("t6_tx_rst", tx_packet_data, 8'h00);
        exp_q.delete();
        @(negedge clk);
        idle_inputs();
        n_rst = 1;
        @(negedge clk);
        chk("t6_occ_after", {1'b0, buffer_occupancy}, 8'd0);
        exp_q.push_back(8'h42);
        step(0, 8'h00, 1, 8'h42, 0, 0, 0);
        pop_check("t6_restart", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
